// File: rtl/op_dispatcher.sv
// op_dispatcher: hands one op at a time to the linear, arc or dummy handler.
// It muxes that handler's motor outputs and counts completed ops.
module op_dispatcher #(
  parameter int PULSE_W     = 11,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clk_en,
  input  logic                       trigger,
  input  logic [2:0]                 op_type,
  output logic                       rdy,
  output logic                       done,
  output logic                       error,
  output logic [2:0]                 h_trigger,
  input  logic [2:0]                 h_rdy,
  input  logic [2:0]                 h_done,
  input  logic [2:0][PULSE_W-1:0]    h_pulse_x,
  input  logic [2:0][PULSE_W-1:0]    h_pulse_y,
  input  logic [2:0]                 h_servo,
  input  logic [2:0]                 h_mtrigger,
  output logic [PULSE_W-1:0]         pulse_num_x,
  output logic [PULSE_W-1:0]         pulse_num_y,
  output logic                       servo_pos,
  output logic                       m_trigger,
  output logic [15:0]                ops_done
);

  localparam int              WD_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam bit              WD_EN   = (TIMEOUT_CYC > 0);

  typedef enum logic [1:0] {IDLE, DISPATCH, WAIT_DONE, DONE} state_t;

  state_t          state_reg, state_next;
  logic [1:0]      sel_reg, sel_next;
  logic            error_reg, error_next;
  logic [WD_W-1:0] wd_cnt_reg, wd_cnt_next;
  logic [15:0]     ops_done_reg, ops_done_next;

  function automatic logic [1:0] sel_of(input logic [2:0] op);
    if (op[2])      return 2'd2;
    else if (op[1]) return 2'd1;
    else            return 2'd0;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      sel_reg      <= 2'd2;
      error_reg    <= 1'b0;
      wd_cnt_reg   <= '0;
      ops_done_reg <= 16'd0;
    end else if (clk_en) begin
      state_reg    <= state_next;
      sel_reg      <= sel_next;
      error_reg    <= error_next;
      wd_cnt_reg   <= wd_cnt_next;
      ops_done_reg <= ops_done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    sel_next      = sel_reg;
    error_next    = error_reg;
    wd_cnt_next   = wd_cnt_reg;
    ops_done_next = ops_done_reg;
    unique case (state_reg)
      IDLE: begin
        if (trigger) begin
          sel_next   = sel_of(op_type);
          error_next = 1'b0;
          state_next = DISPATCH;
        end
      end
      DISPATCH: begin
        if (h_rdy[sel_reg]) begin
          state_next  = WAIT_DONE;
          wd_cnt_next = '0;
        end
      end
      WAIT_DONE: begin
        // A done arriving on the expiry cycle takes priority over the timeout.
        if (h_done[sel_reg]) begin
          state_next = DONE;
        end else if (WD_EN && (wd_cnt_reg == WD_LAST)) begin
          error_next = 1'b1;
          state_next = DONE;
        end else if (WD_EN) begin
          wd_cnt_next = wd_cnt_reg + 1'b1;
        end
      end
      DONE: begin
        ops_done_next = ops_done_reg + 16'd1;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_htrig
      assign h_trigger[gi] = (state_reg == DISPATCH) && (sel_reg == 2'(gi)) && h_rdy[gi];
    end
  endgenerate

  // done is qualified by clk_en so a stalled DONE state still yields a single-cycle pulse.
  assign rdy         = (state_reg == IDLE);
  assign done        = (state_reg == DONE) && clk_en;
  assign error       = error_reg;
  assign ops_done    = ops_done_reg;
  assign pulse_num_x = h_pulse_x[sel_reg];
  assign pulse_num_y = h_pulse_y[sel_reg];
  assign servo_pos   = h_servo[sel_reg];
  assign m_trigger   = (state_reg != IDLE) && h_mtrigger[sel_reg];

endmodule
